next_piece_loader: RTL and testbench

NEXT_PIECE_LOADER -- requirements
Module: next_piece_loader

---
 rtl/next_piece_loader_if.sv | 15 +
 rtl/next_piece_loader.sv | 191 +++++++++++++++++++
 tb/tb_next_piece_loader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/next_piece_loader_if.sv
// rtl/next_piece_loader_if.sv - grid memory bus between the loader and the grid RAM
// Ports (signals):
//   we    - write enable (master drives)
//   addr  - address, read when we=0, write when we=1 (master drives)
//   wdata - write data (master drives)
//   rdata - read data, valid one cycle after addr (slave drives)
interface next_piece_loader_if;
  logic       we;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (output we, output addr, output wdata, input rdata);
  modport slave  (input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/next_piece_loader.sv
// rtl/next_piece_loader.sv - moves the next-piece box contents into the playfield spawn area
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   bus             - grid memory master (we/addr/wdata out, rdata in, 1-cycle read latency)
//   start           - one-cycle load request, honoured only in IDLE
//   busy            - high while scanning, checking or writing
//   done, error     - one-cycle completion pulse; error=1 means aborted with no writes
//   piece_type      - cell value minus one of the last successful load
//   cell_1..4_addr  - playfield addresses of the last successful load, box order
module next_piece_loader #(
  parameter logic [7:0] BOX_BASE   = 8'd232,
  parameter logic [7:0] SPAWN_BASE = 8'd3,
  parameter logic [7:0] COLS       = 8'd10
) (
  input  logic                       clk,
  input  logic                       rst,
  next_piece_loader_if.master        bus,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [2:0]                 piece_type,
  output logic [7:0]                 cell_1_addr,
  output logic [7:0]                 cell_2_addr,
  output logic [7:0]                 cell_3_addr,
  output logic [7:0]                 cell_4_addr
);

  typedef enum logic [2:0] {IDLE, SCAN, CHECK, WRITE, DONE} state_t;

  state_t     state, state_n;
  logic [3:0] idx, idx_n;
  logic [2:0] cnt, cnt_n;
  logic       bad, bad_n, coll, coll_n, err_q;
  logic [7:0] dest [4];
  logic [7:0] val  [4];
  logic [3:0] src  [4];

  logic       hit, scan_fail;
  logic [3:0] k;
  logic [7:0] row_off, col;
  logic [7:0] dest_k;
  logic       we_c;
  logic [7:0] addr_c, wdata_c;

  // Box cell whose read data arrives this cycle (address was issued last cycle).
  assign k = idx - 4'd1;

  always_comb begin
    row_off = 8'd0;
    col     = {4'd0, k};
    if (k >= 4'd9) begin
      row_off = 8'(COLS * 8'd3);
      col     = {4'd0, k - 4'd9};
    end else if (k >= 4'd6) begin
      row_off = 8'(COLS * 8'd2);
      col     = {4'd0, k - 4'd6};
    end else if (k >= 4'd3) begin
      row_off = COLS;
      col     = {4'd0, k - 4'd3};
    end
  end

  assign dest_k = SPAWN_BASE + row_off + col;

  // Hit bookkeeping; the decision on the last SCAN cycle must include that cycle's capture.
  assign hit    = (state == SCAN) && (idx != 4'd0) && (bus.rdata != 8'd0);
  assign cnt_n  = (hit && cnt != 3'd5) ? cnt + 3'd1 : cnt;
  assign bad_n  = bad | (hit && ((bus.rdata > 8'd7) || (cnt != 3'd0 && bus.rdata != val[0])));
  assign coll_n = coll | ((state == CHECK) && (idx != 4'd0) && (bus.rdata != 8'd0));
  assign scan_fail = (cnt_n != 3'd4) || bad_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 4'd0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    we_c    = 1'b0;
    addr_c  = 8'd0;
    wdata_c = 8'd0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SCAN;
          idx_n   = 4'd0;
        end
      end
      SCAN: begin
        if (idx <= 4'd11) addr_c = BOX_BASE + {4'd0, idx};
        if (idx == 4'd12) begin
          idx_n   = 4'd0;
          state_n = scan_fail ? DONE : CHECK;
        end else begin
          idx_n = idx + 4'd1;
        end
      end
      CHECK: begin
        if (idx <= 4'd3) addr_c = dest[idx[1:0]];
        if (idx == 4'd4) begin
          idx_n   = 4'd0;
          state_n = coll_n ? DONE : WRITE;
        end else begin
          idx_n = idx + 4'd1;
        end
      end
      WRITE: begin
        we_c = 1'b1;
        if (idx <= 4'd3) begin
          addr_c  = dest[idx[1:0]];
          wdata_c = val[idx[1:0]];
        end else begin
          addr_c  = BOX_BASE + {4'd0, src[idx[1:0]]};
          wdata_c = 8'd0;
        end
        if (idx == 4'd7) begin
          idx_n   = 4'd0;
          state_n = DONE;
        end else begin
          idx_n = idx + 4'd1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.we    = we_c;
  assign bus.addr  = addr_c;
  assign bus.wdata = wdata_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= 3'd0;
      bad         <= 1'b0;
      coll        <= 1'b0;
      err_q       <= 1'b0;
      piece_type  <= 3'd0;
      cell_1_addr <= 8'd0;
      cell_2_addr <= 8'd0;
      cell_3_addr <= 8'd0;
      cell_4_addr <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        dest[i] <= 8'd0;
        val[i]  <= 8'd0;
        src[i]  <= 4'd0;
      end
    end else begin
      if (state == IDLE && start) begin
        cnt   <= 3'd0;
        bad   <= 1'b0;
        coll  <= 1'b0;
        err_q <= 1'b0;
      end
      if (state == SCAN) begin
        cnt <= cnt_n;
        bad <= bad_n;
        if (hit && cnt < 3'd4) begin
          dest[cnt[1:0]] <= dest_k;
          val[cnt[1:0]]  <= bus.rdata;
          src[cnt[1:0]]  <= k;
        end
        if (idx == 4'd12) err_q <= scan_fail;
      end
      if (state == CHECK) begin
        coll <= coll_n;
        if (idx == 4'd4) err_q <= coll_n;
      end
      // Latch results on entry to DONE so they are already visible with the done pulse.
      if (state == WRITE && idx == 4'd7) begin
        piece_type  <= val[0][2:0] - 3'd1;
        cell_1_addr <= dest[0];
        cell_2_addr <= dest[1];
        cell_3_addr <= dest[2];
        cell_4_addr <= dest[3];
      end
    end
  end

  assign busy  = (state == SCAN) || (state == CHECK) || (state == WRITE);
  assign done  = (state == DONE);
  assign error = (state == DONE) && err_q;

endmodule

// File: tb/tb_next_piece_loader.sv
// tb/tb_next_piece_loader.sv - scoreboard bench for next_piece_loader against a grid RAM model
module tb_next_piece_loader;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, error;
  logic [2:0] piece_type;
  logic [7:0] cell_1_addr, cell_2_addr, cell_3_addr, cell_4_addr;

  next_piece_loader_if bus ();

  next_piece_loader dut (
    .clk(clk), .rst(rst), .bus(bus), .start(start),
    .busy(busy), .done(done), .error(error), .piece_type(piece_type),
    .cell_1_addr(cell_1_addr), .cell_2_addr(cell_2_addr),
    .cell_3_addr(cell_3_addr), .cell_4_addr(cell_4_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             err;
    int               cyc;
    logic [2:0]       pt;
    logic [3:0][7:0]  a;
  } exp_t;

  logic [7:0] mem [256];
  exp_t       sb [$];
  logic [2:0] good_pt;
  logic [3:0][7:0] good_a;
  int n_vec = 0;
  int n_err = 0;

  always @(posedge clk) bus.rdata <= mem[bus.addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to the next sampling point; writes commit as the RAM would on the coming edge.
  task automatic tick();
    @(negedge clk);
    if (bus.we) mem[bus.addr] = bus.wdata;
  endtask

  function automatic logic [7:0] spawn(input int kk);
    return 8'(3 + (kk / 3) * 10 + kk % 3);
  endfunction

  function automatic exp_t model();
    exp_t e;
    int n = 0;
    logic [7:0] v0 = 8'd0;
    logic bad = 1'b0;
    logic coll = 1'b0;
    logic [3:0][7:0] a = '0;
    for (int kk = 0; kk < 12; kk++) begin
      logic [7:0] v = mem[232 + kk];
      if (v != 8'd0) begin
        if (n == 0) v0 = v;
        if (v != v0 || v > 8'd7) bad = 1'b1;
        if (n < 4) a[n] = spawn(kk);
        n++;
      end
    end
    e.pt = good_pt;
    e.a  = good_a;
    if (n != 4 || bad) begin
      e.err = 1'b1; e.cyc = 14;
    end else begin
      for (int j = 0; j < 4; j++) if (mem[a[j]] != 8'd0) coll = 1'b1;
      if (coll) begin
        e.err = 1'b1; e.cyc = 19;
      end else begin
        e.err = 1'b0; e.cyc = 27; e.pt = 3'(v0 - 8'd1); e.a = a;
      end
    end
    return e;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
  endtask

  task automatic run_load(input string tag, input int p1, input int p2);
    exp_t e, g;
    logic [7:0] snap [256];
    logic [7:0] v;
    int wec = 0;
    int diffs = 0;
    bit seen = 0;
    e = model();
    sb.push_back(e);
    snap = mem;
    g = e;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      start = (c == p1 || c == p2);
      if (bus.we) wec++;
      if (done) begin
        if (!seen) begin
          seen = 1;
          g = sb.pop_front();
          check({tag, "_cycle"}, 64'(c), 64'(g.cyc));
          check({tag, "_error"}, 64'(error), 64'(g.err));
          check({tag, "_ptype"}, 64'(piece_type), 64'(g.pt));
          check({tag, "_addrs"}, {cell_1_addr, cell_2_addr, cell_3_addr, cell_4_addr},
                {g.a[0], g.a[1], g.a[2], g.a[3]});
        end else begin
          check({tag, "_extra_done"}, 64'(c), 64'd0);
        end
      end
      if (seen && c >= g.cyc + 3) break;
    end
    start = 1'b0;
    if (!seen) begin
      check({tag, "_done_timeout"}, 64'd0, 64'd1);
      void'(sb.pop_front());
    end
    check({tag, "_we_count"}, 64'(wec), g.err ? 64'd0 : 64'd8);
    if (!g.err) begin
      for (int kk = 0; kk < 12; kk++) begin
        v = snap[232 + kk];
        if (v != 8'd0) begin
          snap[spawn(kk)] = v;
          snap[232 + kk] = 8'd0;
        end
      end
      good_pt = g.pt;
      good_a  = g.a;
    end
    for (int i = 0; i < 256; i++) if (mem[i] !== snap[i]) diffs++;
    check({tag, "_mem"}, 64'(diffs), 64'd0);
  endtask

  task automatic set_i_piece();
    clear_mem();
    mem[232] = 8'd1; mem[235] = 8'd1; mem[238] = 8'd1; mem[241] = 8'd1;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    good_pt = 3'd0;
    good_a = '0;
    clear_mem();
    tick();
    tick();
    check("reset_outputs",
          {busy, done, error, bus.we, bus.addr, bus.wdata, piece_type,
           cell_1_addr, cell_2_addr, cell_3_addr, cell_4_addr}, 64'd0);
    rst = 1'b0;
    tick();

    set_i_piece();
    run_load("i_piece", 0, 0);
    check("i_piece_addr_const", {good_a[0], good_a[1], good_a[2], good_a[3]},
          {8'd3, 8'd13, 8'd23, 8'd33});

    clear_mem();
    run_load("empty", 0, 0);

    clear_mem();
    mem[238] = 8'd2; mem[239] = 8'd2; mem[241] = 8'd2; mem[242] = 8'd2;
    mem[24] = 8'd5;
    run_load("o_collide", 0, 0);

    clear_mem();
    mem[238] = 8'd2; mem[239] = 8'd2; mem[241] = 8'd2; mem[242] = 8'd2;
    run_load("o_piece", 0, 0);

    set_i_piece();
    mem[242] = 8'd1;
    run_load("five_cells", 0, 0);

    set_i_piece();
    mem[241] = 8'd3;
    run_load("mixed_type", 0, 0);

    clear_mem();
    mem[232] = 8'd8; mem[233] = 8'd8; mem[234] = 8'd8; mem[236] = 8'd8;
    run_load("value_gt7", 0, 0);

    clear_mem();
    mem[232] = 8'd6; mem[233] = 8'd6; mem[234] = 8'd6; mem[236] = 8'd6;
    run_load("t_piece", 0, 0);

    set_i_piece();
    run_load("restart_ignored", 5, 20);

    set_i_piece();
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      tick();
      start = 1'b0;
    end
    rst = 1'b1;
    tick();
    check("midwrite_reset",
          {busy, done, error, bus.we, bus.addr, bus.wdata, piece_type,
           cell_1_addr, cell_2_addr, cell_3_addr, cell_4_addr}, 64'd0);
    rst = 1'b0;
    good_pt = 3'd0;
    good_a = '0;
    tick();

    set_i_piece();
    run_load("after_reset", 0, 0);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1);
  end
endmodule
